// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: requests one word, holds it for decode,
// then redirects on jump/branch or falls through to pc+4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pcplus4,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] pcbranch,
  output logic [31:0] icount,
  output logic        misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic [31:0] icount_q, icount_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        next_misalign;

  // Redirect target for the presented instruction; jump wins over a taken branch.
  always_comb begin
    next_misalign = 1'b0;
    if (jump) begin
      next_pc = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc       = {pcbranch[31:2], 2'b00};
      next_misalign = |pcbranch[1:0];
    end else begin
      next_pc = pcplus4_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcplus4_d  = pcplus4_q;
    icount_d   = icount_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_ack) begin
          instr_d   = imem_rdata;
          pcplus4_d = pc_q + 32'd4;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          pc_d       = next_pc;
          icount_d   = icount_q + 32'd1;
          misalign_d = misalign_q | next_misalign;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pcplus4_q  <= 32'd0;
      icount_q   <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pcplus4_q  <= pcplus4_d;
      icount_q   <= icount_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StHold);
  assign pcplus4     = pcplus4_q;
  assign icount      = icount_q;
  assign misalign    = misalign_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 The block SHALL have port imem_ack, input, 1, single-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 The block SHALL have port instr, output, 32, registered instruction presented to the decode/controller stage.
REQ-009 The block SHALL have port instr_valid, output, 1, instr holds an unconsumed instruction.
REQ-010 The block SHALL have port instr_ready, input, 1, decode consumes instr this cycle.
REQ-011 The block SHALL have port pcplus4, output, 32, address of the presented instr plus 4.
REQ-012 The block SHALL have port pcsrc, input, 1, taken-branch indication for the presented instr.
REQ-013 The block SHALL have port jump, input, 1, jump indication for the presented instr.
REQ-014 The block SHALL have port pcbranch, input, 32, branch target for the presented instr.
REQ-015 The block SHALL have port icount, output, 32, count of consumed instructions.
REQ-016 The block SHALL have port misalign, output, 1, sticky flag for a non-word-aligned branch target.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-018 IDLE SHALL hold for reset only; the first rising edge with reset high SHALL move IDLE->REQ with pc = RESET_PC.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr = pc; both SHALL stay stable until the edge that samples imem_ack=1.
REQ-020 On an edge with state REQ and imem_ack=1: instr <= imem_rdata, pcplus4 <= pc+4, state <= HOLD; instr_valid is 1 from the next cycle.
REQ-021 imem_ack SHALL be ignored in IDLE and HOLD.
REQ-022 In HOLD, instr_valid=1 and imem_req=0; instr and pcplus4 SHALL hold until instr_ready=1 is sampled.
REQ-023 On an edge with HOLD and instr_ready=1: pc <= next address, icount <= icount+1, state <= REQ.
REQ-024 The next address SHALL be {pcplus4[31:28], instr[25:0], 2'b00} if jump=1; else pcbranch if pcsrc=1; else pcplus4.
REQ-025 jump SHALL take priority when jump and pcsrc are both 1.
REQ-026 pcsrc, jump and pcbranch SHALL be sampled only on the consuming edge and ignored otherwise.
REQ-027 If a selected pcbranch has bits [1:0] != 0, pc SHALL take pcbranch with bits [1:0] forced to 00, and misalign SHALL set and stay 1 until reset.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); icount SHALL wrap modulo 2^32.
REQ-029 instr_ready when instr_valid=0 SHALL have no effect.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles: zero-wait ack plus an immediate ready.
REQ-031 No prefetch: at most one request SHALL be outstanding, and no request is issued while instr_valid=1.

Reset
REQ-032 reset=0 SHALL immediately force state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, pcplus4=0, icount=0, misalign=0, pc=RESET_PC, regardless of the clock.
REQ-033 Reset asserted mid-REQ or mid-HOLD SHALL drop the request/instruction; a late imem_ack during reset SHALL be ignored.

Verification
REQ-034 Reset release, ack on the 1st REQ cycle with rdata=32'h2008_0005 -> imem_addr=0; instr=32'h2008_0005, instr_valid=1 the next cycle; pcplus4=4.
REQ-035 Sequential: 3 instrs, zero-wait ack, ready always 1 -> addrs 0,4,8; icount=3 after 6 cycles.
REQ-036 Branch: presented instr at 0x10 with pcsrc=1, pcbranch=0x40 -> next imem_addr=0x40; with jump=1 also set and instr=32'h0800_0020 -> next addr 0x80.
REQ-037 Backpressure: ready=0 for 4 cycles -> instr and pcplus4 stable, imem_req=0; ack pulses ignored; resumes on ready.
REQ-038 Boundaries: RESET_PC=32'hFFFF_FFFC sequential -> next addr 0; pcbranch=0x43 -> addr 0x40 and misalign=1 sticky; reset mid-REQ -> imem_req=0 asynchronously and refetch from RESET_PC.
